// File: rtl/hazard_detect_unit_if.sv
// Signal bundle between the pipeline registers and the hazard detection unit.
// The pipeline side uses the master modport; the hazard unit uses the slave modport.
interface hazard_detect_unit_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IF_ID_RS_addr_i;
    logic [4:0]       IF_ID_RT_addr_i;
    logic [4:0]       ID_EX_RT_addr_i;
    logic             ID_EX_MemRead_i;
    logic             Branch_taken_i;
    logic             PC_Write_o;
    logic             IF_ID_Write_o;
    logic             IF_ID_Flush_o;
    logic             ID_EX_Flush_o;
    logic             EX_MEM_Flush_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output IF_ID_RS_addr_i, IF_ID_RT_addr_i, ID_EX_RT_addr_i,
               ID_EX_MemRead_i, Branch_taken_i,
        input  PC_Write_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Flush_o,
               EX_MEM_Flush_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  IF_ID_RS_addr_i, IF_ID_RT_addr_i, ID_EX_RT_addr_i,
               ID_EX_MemRead_i, Branch_taken_i,
        output PC_Write_o, IF_ID_Write_o, IF_ID_Flush_o, ID_EX_Flush_o,
               EX_MEM_Flush_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/hazard_detect_unit.sv
// Load-use stall and branch flush controller for the 5-stage pipeline,
// with saturating stall-cycle and flush-event performance counters.
module hazard_detect_unit #(
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16
) (
    input logic                clk_i,
    input logic                rst_i,
    hazard_detect_unit_if.slave hd
);
    typedef enum logic {
        RUN,
        STALL
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       rem_q, rem_d;
    logic             hazard;
    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             ex_mem_flush;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    assign hazard = hd.ID_EX_MemRead_i
                  & (hd.ID_EX_RT_addr_i != 5'd0)
                  & ((hd.ID_EX_RT_addr_i == hd.IF_ID_RS_addr_i)
                   | (hd.ID_EX_RT_addr_i == hd.IF_ID_RT_addr_i));

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= RUN;
            rem_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    // Stall cycles ignore the hazard input: the bubble already cleared MemRead in ID/EX.
    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        if (!rst_i) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            state_d     = RUN;
            rem_d       = 2'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (hd.Branch_taken_i) begin
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        ex_mem_flush = 1'b1;
                    end else if (hazard) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                        if (LOAD_STALL > 1) begin
                            state_d = STALL;
                            rem_d   = 2'(LOAD_STALL - 1);
                        end
                    end
                end
                STALL: begin
                    if (hd.Branch_taken_i) begin
                        if_id_flush  = 1'b1;
                        id_ex_flush  = 1'b1;
                        ex_mem_flush = 1'b1;
                        state_d      = RUN;
                        rem_d        = 2'd0;
                    end else begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                        if (rem_q <= 2'd1) begin
                            state_d = RUN;
                            rem_d   = 2'd0;
                        end else begin
                            rem_d = rem_q - 2'd1;
                        end
                    end
                end
                default: begin
                    state_d = RUN;
                    rem_d   = 2'd0;
                end
            endcase
        end
    end

    // Counters stick at all-ones rather than wrapping so long runs stay meaningful.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_write && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (ex_mem_flush && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign hd.PC_Write_o     = pc_write;
    assign hd.IF_ID_Write_o  = if_id_write;
    assign hd.IF_ID_Flush_o  = if_id_flush;
    assign hd.ID_EX_Flush_o  = id_ex_flush;
    assign hd.EX_MEM_Flush_o = ex_mem_flush;
    assign hd.stall_cnt_o    = stall_cnt_q;
    assign hd.flush_cnt_o    = flush_cnt_q;
endmodule

// File: tb/tb_hazard_detect_unit.sv
// Directed bench for hazard_detect_unit: three instances (LOAD_STALL=1, LOAD_STALL=3,
// and a 4-bit counter build) share stimulus and are checked against hand-computed values.
module tb_hazard_detect_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_detect_unit_if #(.CNT_W(16)) ia ();
    hazard_detect_unit_if #(.CNT_W(16)) ib ();
    hazard_detect_unit_if #(.CNT_W(4))  ic ();

    hazard_detect_unit #(.LOAD_STALL(1), .CNT_W(16)) dut_a (.clk_i(clk), .rst_i(rst_n), .hd(ia));
    hazard_detect_unit #(.LOAD_STALL(3), .CNT_W(16)) dut_b (.clk_i(clk), .rst_i(rst_n), .hd(ib));
    hazard_detect_unit #(.LOAD_STALL(1), .CNT_W(4))  dut_c (.clk_i(clk), .rst_i(rst_n), .hd(ic));

    // {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush}
    localparam logic [4:0] C_OFF    = 5'b00000;
    localparam logic [4:0] C_RUN    = 5'b11000;
    localparam logic [4:0] C_STALL  = 5'b00010;
    localparam logic [4:0] C_BRANCH = 5'b11111;

    logic [4:0] ctrl_a, ctrl_b, ctrl_c;
    assign ctrl_a = {ia.PC_Write_o, ia.IF_ID_Write_o, ia.IF_ID_Flush_o, ia.ID_EX_Flush_o, ia.EX_MEM_Flush_o};
    assign ctrl_b = {ib.PC_Write_o, ib.IF_ID_Write_o, ib.IF_ID_Flush_o, ib.ID_EX_Flush_o, ib.EX_MEM_Flush_o};
    assign ctrl_c = {ic.PC_Write_o, ic.IF_ID_Write_o, ic.IF_ID_Flush_o, ic.ID_EX_Flush_o, ic.EX_MEM_Flush_o};

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] ex_rt;
        logic       mem_read;
        logic       branch;
        logic [4:0] exp_ctrl;
    } vec_t;

    vec_t vecs[10];

    task automatic apply_stimulus(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ex_rt,
                                  input logic mem_read, input logic branch);
        ia.IF_ID_RS_addr_i = rs;  ib.IF_ID_RS_addr_i = rs;  ic.IF_ID_RS_addr_i = rs;
        ia.IF_ID_RT_addr_i = rt;  ib.IF_ID_RT_addr_i = rt;  ic.IF_ID_RT_addr_i = rt;
        ia.ID_EX_RT_addr_i = ex_rt; ib.ID_EX_RT_addr_i = ex_rt; ic.ID_EX_RT_addr_i = ex_rt;
        ia.ID_EX_MemRead_i = mem_read; ib.ID_EX_MemRead_i = mem_read; ic.ID_EX_MemRead_i = mem_read;
        ia.Branch_taken_i = branch; ib.Branch_taken_i = branch; ic.Branch_taken_i = branch;
    endtask

    task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        apply_stimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        next_cycle();
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_stall;
        int exp_flush;

        vecs[0] = '{5'd5,  5'd0,  5'd5,  1'b1, 1'b0, C_STALL};
        vecs[1] = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, C_RUN};
        vecs[2] = '{5'd2,  5'd9,  5'd9,  1'b1, 1'b0, C_STALL};
        vecs[3] = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b0, C_RUN};
        vecs[4] = '{5'd3,  5'd4,  5'd7,  1'b1, 1'b0, C_RUN};
        vecs[5] = '{5'd7,  5'd7,  5'd7,  1'b0, 1'b0, C_RUN};
        vecs[6] = '{5'd5,  5'd5,  5'd5,  1'b1, 1'b1, C_BRANCH};
        vecs[7] = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b1, C_BRANCH};
        vecs[8] = '{5'd31, 5'd1,  5'd31, 1'b1, 1'b0, C_STALL};
        vecs[9] = '{5'd0,  5'd12, 5'd0,  1'b1, 1'b0, C_RUN};

        // Reset held with a live hazard on the inputs
        rst_n = 1'b0;
        apply_stimulus(5'd5, 5'd0, 5'd5, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            check_output("reset_ctrl_a", 16'(ctrl_a), 16'(C_OFF));
            check_output("reset_ctrl_b", 16'(ctrl_b), 16'(C_OFF));
        end
        check_output("reset_stall_cnt_a", ia.stall_cnt_o, 16'd0);
        check_output("reset_flush_cnt_a", ia.flush_cnt_o, 16'd0);
        apply_stimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        rst_n = 1'b1;
        #1;
        check_output("release_ctrl_a", 16'(ctrl_a), 16'(C_RUN));

        // Table of single-cycle decisions on the LOAD_STALL=1 instance
        exp_stall = 0;
        exp_flush = 0;
        for (int i = 0; i < 10; i++) begin
            next_cycle();
            apply_stimulus(vecs[i].rs, vecs[i].rt, vecs[i].ex_rt, vecs[i].mem_read, vecs[i].branch);
            #1;
            check_output($sformatf("vec%0d_ctrl_a", i), 16'(ctrl_a), 16'(vecs[i].exp_ctrl));
            if (!vecs[i].exp_ctrl[4]) exp_stall++;
            if (vecs[i].exp_ctrl[0]) exp_flush++;
        end
        next_cycle();
        apply_stimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        check_output("table_stall_cnt_a", ia.stall_cnt_o, 16'(exp_stall));
        check_output("table_flush_cnt_a", ia.flush_cnt_o, 16'(exp_flush));

        // LOAD_STALL=3: three freeze cycles, then a back-to-back load restarts the stall
        pulse_reset();
        apply_stimulus(5'd5, 5'd0, 5'd5, 1'b1, 1'b0);
        #1;
        check_output("ls3_c1", 16'(ctrl_b), 16'(C_STALL));
        next_cycle();
        apply_stimulus(5'd5, 5'd0, 5'd5, 1'b0, 1'b0);
        #1;
        check_output("ls3_c2", 16'(ctrl_b), 16'(C_STALL));
        next_cycle();
        check_output("ls3_c3", 16'(ctrl_b), 16'(C_STALL));
        next_cycle();
        check_output("ls3_stall_cnt", ib.stall_cnt_o, 16'd3);
        apply_stimulus(5'd5, 5'd0, 5'd5, 1'b1, 1'b0);
        #1;
        check_output("ls3_b2b_c1", 16'(ctrl_b), 16'(C_STALL));
        next_cycle();
        apply_stimulus(5'd5, 5'd0, 5'd5, 1'b0, 1'b0);
        #1;
        check_output("ls3_b2b_c2", 16'(ctrl_b), 16'(C_STALL));
        next_cycle();
        check_output("ls3_b2b_c3", 16'(ctrl_b), 16'(C_STALL));
        next_cycle();
        check_output("ls3_b2b_exit", 16'(ctrl_b), 16'(C_RUN));
        check_output("ls3_b2b_stall_cnt", ib.stall_cnt_o, 16'd6);

        // Reset in the middle of a stall abandons it
        apply_stimulus(5'd5, 5'd0, 5'd5, 1'b1, 1'b0);
        next_cycle();
        rst_n = 1'b0;
        apply_stimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        check_output("midstall_reset_ctrl", 16'(ctrl_b), 16'(C_OFF));
        next_cycle();
        rst_n = 1'b1;
        #1;
        check_output("midstall_release", 16'(ctrl_b), 16'(C_RUN));
        next_cycle();
        check_output("midstall_run", 16'(ctrl_b), 16'(C_RUN));
        check_output("midstall_stall_cnt", ib.stall_cnt_o, 16'd0);

        // Branch in the second stall cycle aborts the stall
        pulse_reset();
        apply_stimulus(5'd5, 5'd0, 5'd5, 1'b1, 1'b0);
        #1;
        check_output("brstall_c1", 16'(ctrl_b), 16'(C_STALL));
        next_cycle();
        apply_stimulus(5'd5, 5'd0, 5'd5, 1'b0, 1'b1);
        #1;
        check_output("brstall_c2", 16'(ctrl_b), 16'(C_BRANCH));
        next_cycle();
        apply_stimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        check_output("brstall_c3", 16'(ctrl_b), 16'(C_RUN));
        check_output("brstall_flush_cnt", ib.flush_cnt_o, 16'd1);
        check_output("brstall_stall_cnt", ib.stall_cnt_o, 16'd1);

        // 4-bit counter saturates at 15 under 20 hazard cycles
        pulse_reset();
        apply_stimulus(5'd5, 5'd0, 5'd5, 1'b1, 1'b0);
        #1;
        check_output("sat_ctrl", 16'(ctrl_c), 16'(C_STALL));
        for (int i = 1; i <= 20; i++) begin
            next_cycle();
            if (i == 14) check_output("sat_cnt14", 16'(ic.stall_cnt_o), 16'd14);
            if (i == 20) check_output("sat_cnt20", 16'(ic.stall_cnt_o), 16'd15);
        end
        apply_stimulus(5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hazard_detect_unit.md
# hazard_detect_unit

Pipeline hazard controller for the 5-stage MIPS pipeline; it is the stall and flush side of the data path that the forwarding logic cannot cover. It detects load-use hazards between the ID/EX load and the instruction in IF/ID, then freezes PC and IF/ID while inserting bubbles into ID/EX for a configurable number of cycles. It flushes the younger stages on a taken branch and keeps saturating stall and flush counters for performance measurement. It sits alongside the pipeline registers and drives their write-enable and flush controls.

## Interface
- LOAD_STALL, 1: number of bubble cycles per load-use hazard, range 1..3 (memory read latency).
- CNT_W, 16: width of performance counters.

Ports:
- clk_i  input  1  pipeline clock.
- rst_i  input  1  synchronous, active-low reset.
- IF_ID_RS_addr_i  input  5  rs field of the instruction in IF/ID.
- IF_ID_RT_addr_i  input  5  rt field of the instruction in IF/ID.
- ID_EX_RT_addr_i  input  5  destination (rt) of the instruction in ID/EX.
- ID_EX_MemRead_i  input  1  ID/EX instruction is a load.
- Branch_taken_i  input  1  branch resolved taken this cycle (EX/MEM stage).
- PC_Write_o  output  1  PC register load enable.
- IF_ID_Write_o  output  1  IF/ID register load enable.
- IF_ID_Flush_o  output  1  clear IF/ID to a NOP.
- ID_EX_Flush_o  output  1  load a bubble (all controls 0) into ID/EX.
- EX_MEM_Flush_o  output  1  clear EX/MEM control bits.
- stall_cnt_o  output  CNT_W  cycles with PC_Write_o=0 since reset, saturating.
- flush_cnt_o  output  CNT_W  branch flush events since reset, saturating.

## Operation
- hazard = ID_EX_MemRead_i & (ID_EX_RT_addr_i != 0) & ((ID_EX_RT_addr_i == IF_ID_RS_addr_i) | (ID_EX_RT_addr_i == IF_ID_RT_addr_i)).
- FSM states: RUN, STALL. The 2-bit down-counter rem holds the remaining bubble cycles.
- RUN, Branch_taken_i=1: IF_ID_Flush_o=ID_EX_Flush_o=EX_MEM_Flush_o=1, PC_Write_o=IF_ID_Write_o=1. Stay in RUN. Branch takes priority over hazard.
- RUN, hazard=1, no branch: PC_Write_o=IF_ID_Write_o=0, ID_EX_Flush_o=1. If LOAD_STALL>1, go to STALL with rem=LOAD_STALL-1. Otherwise stay in RUN.
- RUN, neither: PC_Write_o=IF_ID_Write_o=1, all flushes 0.
- STALL, no branch: same outputs as a hazard cycle, regardless of the hazard input. This matters because the inserted bubble has cleared ID_EX_MemRead_i. Decrement rem; return to RUN when rem reaches 1 at the clock edge.
- STALL, Branch_taken_i=1: branch outputs as in RUN; abort the stall; next state RUN, rem=0.
- Counters: stall_cnt_o increments on every cycle with PC_Write_o=0. flush_cnt_o increments on every cycle with EX_MEM_Flush_o=1. Both hold at 2^CNT_W-1 with no wrap.
- Outputs are combinational from state, rem and inputs. Counters and FSM are registered.

## Timing
- Reset (rst_i=0 sampled at a clock edge): next state RUN, rem=0, both counters 0.
- While rst_i=0: PC_Write_o=IF_ID_Write_o=0 and all flush outputs 0. This reset override of the outputs is combinational.
- Reset mid-STALL: stall abandoned; RUN from the first cycle with rst_i=1.
- Hazard response latency: 0 cycles (same cycle as the hazard condition). Total freeze per hazard is exactly LOAD_STALL cycles.
- Branch flush: single cycle, same cycle as Branch_taken_i.
- Back-to-back loads: a new hazard detected in RUN on the cycle right after STALL exits starts a fresh stall.
- Register $0 never causes a stall.

## Test plan
- Reset: hold rst_i=0 for 3 cycles with hazard inputs active -> all control outputs 0, counters 0; the first cycle after release is RUN with PC_Write_o=1.
- Load-use, LOAD_STALL=1: ID_EX_MemRead_i=1, ID_EX_RT=5, IF_ID_RS=5 -> one cycle with PC_Write_o=0 and ID_EX_Flush_o=1; next cycle (MemRead=0) PC_Write_o=1; stall_cnt_o=1.
- Load-use, LOAD_STALL=3: same stimulus, with MemRead dropped after the first cycle -> exactly 3 freeze cycles; stall_cnt_o=3.
- $0 and no-match cases: ID_EX_RT=0 with IF_ID_RS=0 -> no stall; ID_EX_RT=7 with IF_ID_RS=3 and IF_ID_RT=4 -> no stall.
- Branch during STALL (LOAD_STALL=3): assert Branch_taken_i in the 2nd stall cycle -> all three flush outputs 1 and PC_Write_o=1 that cycle; RUN the next cycle; flush_cnt_o=1, stall_cnt_o=1.
- Saturation (CNT_W=4): force 20 consecutive hazard cycles -> stall_cnt_o holds at 15.
